// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, write-allocate data cache, one 32-bit word per line.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        CPU data port request (held by the CPU while cpu_stall=1)
//   cpu_rdata, cpu_stall         load data, pipeline freeze
//   mem_req/we/addr/wdata        data memory request, held stable until mem_ack
//   mem_ack, mem_rdata           single-cycle completion pulse and read data
//   hit_cnt, miss_cnt            saturating load hit/miss counters
module dcache_wt #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 30 - INDEX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic [31:0]        data_q [LINES];
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        fill_q, fill_d;
    logic [31:0]        hit_cnt_q, hit_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;
    logic [INDEX_W-1:0] idx, fill_idx;
    logic [TAG_W-1:0]   tag, fill_tag;
    logic               hit, line_we;
    logic [31:0]        line_data;

    assign idx       = cpu_addr[INDEX_W+1:2];
    assign tag       = cpu_addr[31:INDEX_W+2];
    assign fill_idx  = addr_q[INDEX_W+1:2];
    assign fill_tag  = addr_q[31:INDEX_W+2];
    assign hit       = valid_q[idx] && tag_q[idx] == tag;
    // Both miss fill and write-through allocate the line on the accepted ack.
    assign line_we   = mem_req && mem_ack;
    assign line_data = state_q == RD_MISS ? mem_rdata : wdata_q;

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fill_d     = fill_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        cpu_stall  = 1'b0;
        cpu_rdata  = '0;
        case (state_q)
            IDLE: if (cpu_req) begin
                if (!cpu_we && hit) begin
                    cpu_rdata = data_q[idx];
                    hit_cnt_d = hit_cnt_q + {31'd0, ~&hit_cnt_q};
                end else begin
                    cpu_stall = 1'b1;
                    addr_d    = cpu_addr & ~32'd3;
                    if (cpu_we) begin
                        wdata_d = cpu_wdata;
                        state_d = WR_THRU;
                    end else begin
                        miss_cnt_d = miss_cnt_q + {31'd0, ~&miss_cnt_q};
                        state_d    = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                mem_req   = 1'b1;
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    fill_d            = mem_rdata;
                    valid_d[fill_idx] = 1'b1;
                    state_d           = DONE;
                end
            end
            WR_THRU: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    valid_d[fill_idx] = 1'b1;
                    state_d           = DONE;
                end
            end
            default: begin
                // Hand the filled word back while the CPU advances; the request is not re-examined.
                cpu_rdata = fill_q;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            fill_q     <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fill_q     <= fill_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag/data storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!rst && line_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= line_data;
        end
    end
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: randomized self-checking bench for dcache_wt against a transaction-level cache/memory model.
module tb_dcache_wt;
    localparam int IW = 4;
    localparam int LN = 1 << IW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] hit_cnt, miss_cnt;

    dcache_wt #(.INDEX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents by word address; the cache is write-through, so every load must return this.
    logic [31:0] mem_m [logic [29:0]];
    // Which word address each line currently holds.
    bit          line_v [LN];
    logic [31:0] line_a [LN];

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        logic [29:0] w;
        w = wa[31:2];
        if (mem_m.exists(w)) return mem_m[w];
        return {w, 2'b10} ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    bit          chk_en = 1'b0;
    logic        e_stall, e_mreq, e_mwe;
    logic [31:0] e_maddr, e_mwdata, e_rdata;
    bit          e_rd_chk = 1'b0;
    logic [31:0] e_hit = '0, e_miss = '0;
    int          run = 0, last_run = 0;

    always @(negedge clk) begin
        if (rst) run = 0;
        else if (cpu_stall) run++;
        else if (run > 0) begin
            last_run = run;
            run = 0;
        end
        if (chk_en) begin
            check("stall", cpu_stall, e_stall);
            check("mem_req", mem_req, e_mreq);
            check("mem_we", mem_we, e_mwe);
            if (e_mreq) check("mem_addr", mem_addr, e_maddr);
            if (e_mwe) check("mem_wdata", mem_wdata, e_mwdata);
            if (e_rd_chk) check("cpu_rdata", cpu_rdata, e_rdata);
            check("hit_cnt", hit_cnt, e_hit);
            check("miss_cnt", miss_cnt, e_miss);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit spurious);
        cpu_req = 1'b0; e_stall = 1'b0; e_mreq = 1'b0; e_mwe = 1'b0; e_rd_chk = 1'b0;
        repeat (n) begin
            mem_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
            cyc();
        end
        mem_ack = 1'b0;
    endtask

    // One CPU access; the bench doubles as the memory, acking lat cycles after the first mem_req cycle.
    task automatic access(input bit we, input logic [31:0] a, input logic [31:0] d, input int lat);
        logic [31:0] wa;
        int          ix;
        bit          hit;
        wa = a & ~32'd3;
        ix = int'(a[IW+1:2]);
        hit = line_v[ix] && line_a[ix] == wa;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; mem_ack = 1'b0;
        e_mreq = 1'b0; e_mwe = 1'b0; e_rd_chk = 1'b0;
        if (!we && hit) begin
            e_stall = 1'b0; e_rd_chk = 1'b1; e_rdata = mem_rd(wa);
            cyc();
            e_hit = sat(e_hit);
            idle(0, 1'b0);
            return;
        end
        e_stall = 1'b1;
        cyc();
        if (!we) e_miss = sat(e_miss);
        e_mreq = 1'b1; e_mwe = we; e_maddr = wa; e_mwdata = d;
        for (int k = 0; k <= lat; k++) begin
            mem_ack = (k == lat);
            mem_rdata = (k == lat && !we) ? mem_rd(wa) : $urandom;
            cyc();
        end
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (we) mem_m[wa[31:2]] = d;
        line_v[ix] = 1'b1; line_a[ix] = wa;
        e_mreq = 1'b0; e_mwe = 1'b0; e_stall = 1'b0;
        e_rd_chk = !we; e_rdata = mem_rd(wa);
        cyc();
        idle(0, 1'b0);
    endtask

    initial begin
        e_stall = 1'b0; e_mreq = 1'b0; e_mwe = 1'b0; e_maddr = '0; e_mwdata = '0; e_rdata = '0;
        for (int i = 0; i < LN; i++) line_v[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_stall", cpu_stall, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_hit", hit_cnt, 0);
        check("rst_miss", miss_cnt, 0);
        chk_en = 1'b1;

        mem_m[30'h10] = 32'hDEAD_BEEF;
        access(1'b0, 32'h40, 32'h0, 3);
        check("cold_stall_len", last_run, 5);
        check("cold_mem_addr", mem_addr, 32'h40);
        check("cold_miss", miss_cnt, 1);
        access(1'b0, 32'h40, 32'h0, 0);
        check("hit_cnt1", hit_cnt, 1);
        access(1'b1, 32'h80, 32'h1234_5678, 0);
        check("st_stall_len", last_run, 2);
        check("st_mem_wdata", mem_wdata, 32'h1234_5678);
        access(1'b0, 32'h80, 32'h0, 1);
        check("conf_hit", hit_cnt, 2);
        access(1'b0, 32'h40, 32'h0, 2);
        check("conf_miss", miss_cnt, 2);
        check("conf_addr", mem_addr, 32'h40);
        access(1'b0, 32'h43, 32'h0, 0);
        check("ignored_bits_hit", hit_cnt, 3);
        idle(1, 1'b0);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        access(1'b0, 32'h40, 32'h0, 0);
        check("spurious_ack_hit", hit_cnt, 4);

        force dut.hit_cnt_q = 32'hFFFF_FFFE;
        e_hit = 32'hFFFF_FFFE;
        idle(1, 1'b0);
        release dut.hit_cnt_q;
        repeat (3) access(1'b0, 32'h40, 32'h0, 0);
        check("sat_hit", hit_cnt, 32'hFFFF_FFFF);

        chk_en = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        cyc();
        check("rm_req1", mem_req, 1);
        cyc();
        rst = 1'b1; cpu_req = 1'b0;
        cyc();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        check("rm_req_after_rst", mem_req, 0);
        check("rm_stall_after_rst", cpu_stall, 0);
        cyc();
        mem_ack = 1'b0;
        check("rm_req_late_ack", mem_req, 0);
        check("rm_hit0", hit_cnt, 0);
        check("rm_miss0", miss_cnt, 0);
        for (int i = 0; i < LN; i++) line_v[i] = 1'b0;
        e_hit = '0; e_miss = '0;
        e_stall = 1'b0; e_mreq = 1'b0; e_mwe = 1'b0;
        chk_en = 1'b1;
        mem_m[30'h40] = 32'hCAFE_F00D;
        access(1'b0, 32'h100, 32'h0, 1);
        check("rm_remiss", miss_cnt, 1);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a[31:24] = 8'($urandom);
            access($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(0, 4));
            idle($urandom_range(0, 2), 1'b1);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, write-allocate data cache with one 32-bit word per line.
- Sits directly downstream of the pipelined CPU's MEM stage, between the CPU data port (address, write data, write enable, read data) and a slower data memory with a req/ack handshake.
- Asserts cpu_stall while a miss or a write-through is outstanding, so the pipeline freezes.
- Keeps saturating hit and miss counters for performance measurement.

Parameters:
- INDEX_W, 4, index bits; the cache holds 2^INDEX_W lines.
- TAG_W, 30-INDEX_W, tag bits (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cpu_req  in  1  access valid this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address; bits [1:0] are ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data.
- cpu_stall  out  1  the CPU must hold all cpu_* inputs and freeze the pipeline.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  single-cycle completion pulse.
- mem_rdata  in  32  read data, valid while mem_ack=1.
- hit_cnt  out  32  load hits, saturating.
- miss_cnt  out  32  load misses, saturating.

Behaviour:
- Address split: index = cpu_addr[INDEX_W+1:2]; tag = cpu_addr[31:INDEX_W+2].
- Hit = valid[index] and tag_arr[index]==tag.
- Storage:
  - valid is a register vector.
  - Tag and data arrays are registers, read asynchronously.
- FSM states: IDLE, RD_MISS, WR_THRU, DONE.
- IDLE:
  - cpu_req=0: stall=0, no state change.
  - Load hit: cpu_rdata=data_arr[index] combinationally; stall=0; hit_cnt+1; stay IDLE.
  - Load miss: stall=1; latch addr; miss_cnt+1; next state RD_MISS.
  - Store (hit or miss): stall=1; latch addr and wdata; next state WR_THRU.
- RD_MISS:
  - mem_req=1, mem_we=0, mem_addr={latched addr[31:2],2'b00}; stall=1.
  - On mem_ack: write mem_rdata into the line, set valid and tag, capture the data into a fill register, next state DONE.
- WR_THRU:
  - mem_req=1, mem_we=1, mem_wdata=latched wdata; stall=1.
  - On mem_ack: write the line (allocate; overwrite any conflicting line), set valid and tag, next state DONE.
- DONE:
  - stall=0; cpu_rdata=fill register for a load (don't-care for a store).
  - cpu_req is not evaluated in this cycle; counters are not incremented.
  - Next state IDLE. The CPU advances on this edge.
- Outputs in all other states:
  - mem_req=0 outside RD_MISS/WR_THRU.
  - mem_addr/mem_wdata hold their latched values.
  - mem_we=0 when mem_req=0.
- Handshake: mem_req stays high with stable addr/data until mem_ack. Ack may arrive in the first cycle of mem_req. mem_ack while mem_req=0 is ignored.
- Stall waveform: stall is asserted from the detecting IDLE cycle through the ack cycle inclusive. For an ack N cycles after the first mem_req cycle, stall is high for N+2 cycles.
- Counters: 32-bit, saturate at 0xFFFFFFFF, no wrap.
- Reset:
  - Clears all valid bits, both counters, and the fill register.
  - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; cpu_stall=0; cpu_rdata=0 while not hitting.
- Reset mid-transaction: the request is abandoned immediately, the line is not updated, and a late ack is ignored.
- Simultaneous rst and mem_ack: rst wins.

Test Plan:
- Cold load miss: after reset, load 0x40; mem acks 3 cycles after the first mem_req with 0xDEADBEEF.
  - Required: stall high 5 cycles; mem_addr=0x40, mem_we=0.
  - DONE cycle: cpu_rdata=0xDEADBEEF; miss_cnt=1.
- Load hit: repeat load 0x40 -> stall=0 in the same cycle, cpu_rdata=0xDEADBEEF, hit_cnt=1, mem_req stays 0.
- Store, then load conflict:
  - Store 0x12345678 to 0x80 (same index as 0x40), ack after 0 cycles -> mem_we=1, mem_wdata=0x12345678, stall 2 cycles.
  - Load 0x80 -> hit with 0x12345678.
  - Load 0x40 -> miss with mem_addr=0x40.
- Reset mid-miss: load 0x100 miss, assert rst in the second RD_MISS cycle, ack 1 cycle later.
  - Required: mem_req=0 the cycle after rst; the ack is ignored; load 0x100 misses again; counters=0 before it.
- Ignored address bits and spurious ack:
  - Load 0x43 after 0x40 was filled -> hit.
  - mem_ack pulsed in IDLE -> no state change.
- Counter saturation: force hit_cnt to 0xFFFFFFFE, perform 3 hits -> hit_cnt=0xFFFFFFFF.
